sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter.sv | 111 +++++++++++
 tb/tb_sram_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates fetch and MEM onto one single-port SRAM; data wins ties unless fetch has starved STARVE_MAX cycles.
// Grant is combinational, response one cycle later, no stall path; `ARB_PERF_CNT_EN adds conflict/starvation counters.
module sram_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] conflict_cnt,
  output logic [31:0] starve_evt_cnt,
`endif
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        cancel,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       resp_valid_q, resp_valid_d;
  logic       resp_owner_q, resp_owner_d;
  logic       resp_drop_q, resp_drop_d;
  logic       resp_wr_q, resp_wr_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       inst_pri, grant_inst, grant_data;

  always_comb begin
    inst_pri   = (starve_cnt_q == STARVE_LIM);
    grant_inst = ~reset & inst_req & ~cancel & (~data_req | inst_pri);
    grant_data = ~reset & data_req & ~grant_inst;

    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    sram_en      = grant_inst | grant_data;
    sram_wen     = (grant_data & data_wr) ? data_wstrb : 4'b0000;
    sram_addr    = grant_inst ? inst_addr : data_addr;
    sram_wdata   = data_wdata;

    // A denied-but-cancelled fetch still ages, so it wins as soon as cancel drops.
    starve_cnt_d = starve_cnt_q;
    if (!inst_req || grant_inst)
      starve_cnt_d = 4'd0;
    else if (starve_cnt_q != STARVE_LIM)
      starve_cnt_d = starve_cnt_q + 4'd1;

    resp_valid_d = grant_inst | grant_data;
    resp_owner_d = grant_data;
    resp_wr_d    = grant_data & data_wr;
    resp_drop_d  = cancel & grant_inst;

    inst_data_ok = ~reset & resp_valid_q & ~resp_owner_q & ~resp_drop_q & ~cancel;
    data_data_ok = ~reset & resp_valid_q & resp_owner_q;
    inst_rdata   = (~reset & resp_valid_q & ~resp_owner_q) ? sram_rdata : 32'd0;
    data_rdata   = (~reset & resp_valid_q & resp_owner_q & ~resp_wr_q) ? sram_rdata : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_drop_q  <= 1'b0;
      resp_wr_q    <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_drop_q  <= resp_drop_d;
      resp_wr_q    <= resp_wr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] starve_evt_cnt_q, starve_evt_cnt_d;

  always_comb begin
    conflict_cnt_d   = conflict_cnt_q + {31'd0, inst_req & data_req};
    starve_evt_cnt_d = starve_evt_cnt_q + {31'd0, grant_inst & data_req & inst_pri};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt_q   <= 32'd0;
      starve_evt_cnt_q <= 32'd0;
    end else begin
      conflict_cnt_q   <= conflict_cnt_d;
      starve_evt_cnt_q <= starve_evt_cnt_d;
    end
  end

  assign conflict_cnt   = conflict_cnt_q;
  assign starve_evt_cnt = starve_evt_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_wr, cancel;
  logic [31:0] inst_addr, data_addr, data_wdata, sram_rdata;
  logic [3:0]  data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en;
  logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
  logic [3:0]  sram_wen;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt, starve_evt_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
`ifdef ARB_PERF_CNT_EN
    .conflict_cnt(conflict_cnt), .starve_evt_cnt(starve_evt_cnt),
`endif
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .cancel(cancel), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; data_req = 1'b1; data_addr = 32'h40; sram_rdata = 32'hFFFF_FFFF;
    #2;
    checks++; if (sram_en !== 1'b0) begin fails++; $display("FAIL reset_sram_en: got %b want 0", sram_en); end
    checks++; if (sram_wen !== 4'b0) begin fails++; $display("FAIL reset_sram_wen: got %b want 0", sram_wen); end
    checks++; if (data_addr_ok !== 1'b0) begin fails++; $display("FAIL reset_data_addr_ok: got %b want 0", data_addr_ok); end
    checks++; if (inst_addr_ok !== 1'b0) begin fails++; $display("FAIL reset_inst_addr_ok: got %b want 0", inst_addr_ok); end
    checks++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin fails++; $display("FAIL reset_data_ok: got %b%b want 00", inst_data_ok, data_data_ok); end
    checks++; if (inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h/%h want 0/0", inst_rdata, data_rdata); end
    data_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_starve();
    logic exp_inst;
    inst_req = 1'b1; inst_addr = 32'h300;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h400;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp_inst = (k == 4);
      checks++; if (inst_addr_ok !== exp_inst || data_addr_ok !== ~exp_inst) begin fails++; $display("FAIL starve_grant_c%0d: got inst=%b data=%b want inst=%b", k, inst_addr_ok, data_addr_ok, exp_inst); end
      checks++; if (sram_addr !== (exp_inst ? 32'h300 : 32'h400)) begin fails++; $display("FAIL starve_addr_c%0d: got %h", k, sram_addr); end
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; sram_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin fails++; $display("FAIL starve_resp: got inst=%b data=%b want 1 0", inst_data_ok, data_data_ok); end
    checks++; if (inst_rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL starve_rdata: got %h want 0badf00d", inst_rdata); end
`ifdef ARB_PERF_CNT_EN
    checks++; if (conflict_cnt !== 32'd5) begin fails++; $display("FAIL perf_conflict: got %0d want 5", conflict_cnt); end
    checks++; if (starve_evt_cnt !== 32'd1) begin fails++; $display("FAIL perf_starve_evt: got %0d want 1", starve_evt_cnt); end
`endif
    tick();
  endtask

  task automatic test_inst_only();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    @(negedge clk);
    checks++; if (inst_addr_ok !== 1'b1 || sram_en !== 1'b1) begin fails++; $display("FAIL inst_only_grant: got ok=%b en=%b want 1 1", inst_addr_ok, sram_en); end
    checks++; if (sram_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL inst_only_addr: got %h want bfc00000", sram_addr); end
    checks++; if (sram_wen !== 4'b0) begin fails++; $display("FAIL inst_only_wen: got %b want 0000", sram_wen); end
    tick();
    inst_req = 1'b0; sram_rdata = 32'h3C1D_BFC0;
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin fails++; $display("FAIL inst_only_resp: got inst=%b data=%b want 1 0", inst_data_ok, data_data_ok); end
    checks++; if (inst_rdata !== 32'h3C1D_BFC0) begin fails++; $display("FAIL inst_only_rdata: got %h want 3c1dbfc0", inst_rdata); end
    tick();
  endtask

  task automatic test_data_priority();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_1000;
    @(negedge clk);
    checks++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin fails++; $display("FAIL prio_grant: got data=%b inst=%b want 1 0", data_addr_ok, inst_addr_ok); end
    checks++; if (sram_addr !== 32'h0000_1000 || sram_wen !== 4'b0) begin fails++; $display("FAIL prio_sram: got addr=%h wen=%b want 00001000 0000", sram_addr, sram_wen); end
    tick();
    inst_req = 1'b0; data_req = 1'b0; sram_rdata = 32'h1122_3344;
    @(negedge clk);
    checks++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin fails++; $display("FAIL prio_resp: got data=%b inst=%b want 1 0", data_data_ok, inst_data_ok); end
    checks++; if (data_rdata !== 32'h1122_3344 || inst_rdata !== 32'd0) begin fails++; $display("FAIL prio_rdata: got %h/%h want 11223344/0", data_rdata, inst_rdata); end
    tick();
  endtask

  task automatic test_write();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011; data_addr = 32'h10; data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (data_addr_ok !== 1'b1 || sram_wen !== 4'b0011) begin fails++; $display("FAIL write_grant: got ok=%b wen=%b want 1 0011", data_addr_ok, sram_wen); end
    checks++; if (sram_wdata !== 32'hDEAD_BEEF || sram_addr !== 32'h10) begin fails++; $display("FAIL write_bus: got wdata=%h addr=%h", sram_wdata, sram_addr); end
    tick();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'b0; sram_rdata = 32'h55AA_55AA;
    @(negedge clk);
    checks++; if (data_data_ok !== 1'b1) begin fails++; $display("FAIL write_ack: got %b want 1", data_data_ok); end
    checks++; if (data_rdata !== 32'd0) begin fails++; $display("FAIL write_rdata: got %h want 0", data_rdata); end
    tick();
  endtask

  task automatic test_cancel();
    inst_req = 1'b1; inst_addr = 32'h100;
    @(negedge clk);
    checks++; if (inst_addr_ok !== 1'b1) begin fails++; $display("FAIL cancel_first_grant: got %b want 1", inst_addr_ok); end
    tick();
    cancel = 1'b1; inst_addr = 32'h104; sram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b0) begin fails++; $display("FAIL cancel_drop_resp: got %b want 0", inst_data_ok); end
    checks++; if (inst_addr_ok !== 1'b0 || sram_en !== 1'b0) begin fails++; $display("FAIL cancel_block_grant: got ok=%b en=%b want 0 0", inst_addr_ok, sram_en); end
    tick();
    cancel = 1'b0;
    @(negedge clk);
    checks++; if (inst_addr_ok !== 1'b1 || sram_addr !== 32'h104) begin fails++; $display("FAIL cancel_regrant: got ok=%b addr=%h want 1 104", inst_addr_ok, sram_addr); end
    checks++; if (inst_data_ok !== 1'b0) begin fails++; $display("FAIL cancel_no_ghost: got %b want 0", inst_data_ok); end
    tick();
    inst_req = 1'b0; sram_rdata = 32'h0000_ABCD;
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0000_ABCD) begin fails++; $display("FAIL cancel_after_resp: got ok=%b rdata=%h want 1 0000abcd", inst_data_ok, inst_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h20;
    @(negedge clk);
    checks++; if (data_addr_ok !== 1'b1) begin fails++; $display("FAIL b2b_data_grant: got %b want 1", data_addr_ok); end
    tick();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h200; sram_rdata = 32'h2020_2020;
    @(negedge clk);
    checks++; if (inst_addr_ok !== 1'b1 || data_data_ok !== 1'b1) begin fails++; $display("FAIL b2b_overlap: got grant=%b resp=%b want 1 1", inst_addr_ok, data_data_ok); end
    checks++; if (data_rdata !== 32'h2020_2020 || inst_rdata !== 32'd0 || inst_data_ok !== 1'b0) begin fails++; $display("FAIL b2b_data_resp: got %h/%h ok=%b", data_rdata, inst_rdata, inst_data_ok); end
    tick();
    inst_req = 1'b0; sram_rdata = 32'h0200_0200;
    @(negedge clk);
    checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h0200_0200) begin fails++; $display("FAIL b2b_inst_resp: got ok=%b/%b rdata=%h", inst_data_ok, data_data_ok, inst_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic exp_inst;
    inst_req = 1'b1; inst_addr = 32'h500;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h600;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++; if (data_addr_ok !== 1'b1) begin fails++; $display("FAIL rstmid_pre_grant%0d: got %b want 1", j, data_addr_ok); end
      tick();
    end
    #1;
    checks++; if (data_data_ok !== 1'b1) begin fails++; $display("FAIL rstmid_pending: got %b want 1", data_data_ok); end
    reset = 1'b1;
    #1;
    checks++; if (data_data_ok !== 1'b0 || sram_en !== 1'b0) begin fails++; $display("FAIL rstmid_async: got ok=%b en=%b want 0 0", data_data_ok, sram_en); end
    checks++; if (data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin fails++; $display("FAIL rstmid_grants: got %b%b want 00", data_addr_ok, inst_addr_ok); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp_inst = (k == 4);
      if (k == 0) begin
        checks++; if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin fails++; $display("FAIL rstmid_spurious: got %b%b want 00", data_data_ok, inst_data_ok); end
      end
      checks++; if (inst_addr_ok !== exp_inst || data_addr_ok !== ~exp_inst) begin fails++; $display("FAIL rstmid_starve_c%0d: got inst=%b data=%b want inst=%b", k, inst_addr_ok, data_addr_ok, exp_inst); end
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; inst_req = 1'b0; inst_addr = 32'd0; data_req = 1'b0; data_wr = 1'b0;
    data_wstrb = 4'd0; data_addr = 32'd0; data_wdata = 32'd0; cancel = 1'b0; sram_rdata = 32'd0;
    test_reset();
    test_starve();
    test_inst_only();
    test_data_priority();
    test_write();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
